// File: rtl/fetch_redirect_unit.sv
// ============================================================================
// Module      : fetch_redirect_unit
// Description : Fetch-stage PC register, next-PC selection and IF/ID pipeline
//               register with execute-stage redirect, flush and stall handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_redirect_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'hBFC00000),
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       PCSrc_E,
    input  logic [WIDTH-1:0] PCTarget_E,
    input  logic [WIDTH-1:0] ALUResult_E,
    input  logic             Stall_F,
    input  logic             Stall_D,
    input  logic [WIDTH-1:0] Instr_F,
    output logic [WIDTH-1:0] PC_F,
    output logic [WIDTH-1:0] PCPlus4_F,
    output logic [WIDTH-1:0] Instr_D,
    output logic [WIDTH-1:0] PC_D,
    output logic [WIDTH-1:0] PCPlus4_D,
    output logic             Valid_D,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic             MisalignFault,
    output logic [CNT_W-1:0] RedirectCount
);

    localparam logic [1:0]       c_src_pc4   = 2'b00;
    localparam logic [1:0]       c_src_jalr  = 2'b11;
    localparam logic [WIDTH-1:0] c_nop_instr = WIDTH'(32'h00000013);
    localparam logic [WIDTH-1:0] c_pc_step   = WIDTH'(4);
    localparam logic [CNT_W-1:0] c_cnt_max   = '1;

    // Registered state
    logic [WIDTH-1:0] r_pc_f;
    logic [WIDTH-1:0] r_instr_d;
    logic [WIDTH-1:0] r_pc_d;
    logic [WIDTH-1:0] r_pc_plus4_d;
    logic             r_valid_d;
    logic             r_misalign;
    logic [CNT_W-1:0] r_redirect_cnt;

    // Next-state values
    logic [WIDTH-1:0] w_pc_f_nxt;
    logic [WIDTH-1:0] w_instr_d_nxt;
    logic [WIDTH-1:0] w_pc_d_nxt;
    logic [WIDTH-1:0] w_pc_plus4_d_nxt;
    logic             w_valid_d_nxt;
    logic             w_misalign_nxt;
    logic [CNT_W-1:0] w_redirect_cnt_nxt;

    logic             w_redirect;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_pc_plus4_f;

    assign w_redirect   = (PCSrc_E != c_src_pc4);
    assign w_pc_plus4_f = r_pc_f + c_pc_step;

    // JALR clears bit 0 of the computed address; branch and JAL use the adder target.
    always_comb begin
        w_target = PCTarget_E;
        if (PCSrc_E == c_src_jalr) begin
            w_target = {ALUResult_E[WIDTH-1:1], 1'b0};
        end
    end

    // Redirect wins over a fetch stall so the squashed path never refetches.
    always_comb begin
        w_pc_f_nxt = w_pc_plus4_f;
        if (w_redirect) begin
            w_pc_f_nxt = {w_target[WIDTH-1:2], 2'b00};
        end else if (Stall_F) begin
            w_pc_f_nxt = r_pc_f;
        end
    end

    // A flush inserts a bubble even while decode is stalled.
    always_comb begin
        w_instr_d_nxt    = Instr_F;
        w_pc_d_nxt       = r_pc_f;
        w_pc_plus4_d_nxt = w_pc_plus4_f;
        w_valid_d_nxt    = 1'b1;
        if (w_redirect) begin
            w_instr_d_nxt    = c_nop_instr;
            w_pc_d_nxt       = '0;
            w_pc_plus4_d_nxt = '0;
            w_valid_d_nxt    = 1'b0;
        end else if (Stall_D) begin
            w_instr_d_nxt    = r_instr_d;
            w_pc_d_nxt       = r_pc_d;
            w_pc_plus4_d_nxt = r_pc_plus4_d;
            w_valid_d_nxt    = r_valid_d;
        end
    end

    always_comb begin
        w_misalign_nxt     = r_misalign;
        w_redirect_cnt_nxt = r_redirect_cnt;
        if (w_redirect) begin
            if (w_target[1]) begin
                w_misalign_nxt = 1'b1;
            end
            if (r_redirect_cnt != c_cnt_max) begin
                w_redirect_cnt_nxt = r_redirect_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_f         <= RESET_PC;
            r_instr_d      <= c_nop_instr;
            r_pc_d         <= '0;
            r_pc_plus4_d   <= '0;
            r_valid_d      <= 1'b0;
            r_misalign     <= 1'b0;
            r_redirect_cnt <= '0;
        end else begin
            r_pc_f         <= w_pc_f_nxt;
            r_instr_d      <= w_instr_d_nxt;
            r_pc_d         <= w_pc_d_nxt;
            r_pc_plus4_d   <= w_pc_plus4_d_nxt;
            r_valid_d      <= w_valid_d_nxt;
            r_misalign     <= w_misalign_nxt;
            r_redirect_cnt <= w_redirect_cnt_nxt;
        end
    end

    assign PC_F          = r_pc_f;
    assign PCPlus4_F     = w_pc_plus4_f;
    assign Instr_D       = r_instr_d;
    assign PC_D          = r_pc_d;
    assign PCPlus4_D     = r_pc_plus4_d;
    assign Valid_D       = r_valid_d;
    assign Flush_D       = w_redirect;
    assign Flush_E       = w_redirect;
    assign MisalignFault = r_misalign;
    assign RedirectCount = r_redirect_cnt;

endmodule

`default_nettype wire
